mips_fetch_ir: RTL
==================

Name: mips_fetch_ir

Overview:
- Instruction fetch and instruction-register stage directly upstream of mips_decode.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Captures the returned word into the IR and slices it into opcode/funct/rs/rt/rd/imm for the decoder and register file.
- Halts permanently when the decoder flags an unrecognised instruction.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset; must be word-aligned.
- PC_STEP, 4, PC increment after each accepted instruction.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
- imem_req  output  1  request to instruction memory; held until ack.
- imem_addr  output  32  word address of request; equals pc while imem_req=1.
- imem_ack  input  1  memory returns imem_data this cycle; ignored unless imem_req=1.
- imem_data  input  32  instruction word, valid when imem_ack=1.
- inst_valid  output  1  IR holds an instruction for the decoder.
- inst_ready  input  1  downstream consumes the IR this cycle when inst_valid=1.
- except  input  1  decoder except for the current IR contents; sampled only when inst_valid=1.
- opcode  output  6  IR[31:26].
- rs  output  5  IR[25:21].
- rt  output  5  IR[20:16].
- rd  output  5  IR[15:11].
- funct  output  6  IR[5:0].
- imm  output  16  IR[15:0].
- pc  output  32  address of the instruction currently in the IR, or of the pending fetch.
- halted  output  1  sticky; stage has stopped on an exception.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=RESET_PC, IR=0.
  - inst_valid=0, halted=0.
  - imem_req goes to 1 on the first edge after reset is released; it is 0 while reset is asserted.
- States: FETCH, HOLD, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, inst_valid=0.
  - On an edge with imem_ack=1: IR<=imem_data, go to HOLD.
  - imem_ack may arrive in the first FETCH cycle, giving a minimum fetch latency of 1 cycle (req to IR loaded).
  - Without ack, imem_req and imem_addr stay stable.
- HOLD:
  - imem_req=0, inst_valid=1.
  - IR and all field outputs stay stable until accepted.
  - except=1 with inst_valid=1: go to HALT. The except check takes priority over inst_ready. pc is not advanced. IR is retained for debug.
  - inst_ready=1 and except=0: pc<=pc+PC_STEP (mod 2^32, wraps silently), go to FETCH.
  - Otherwise remain in HOLD (stall).
- HALT:
  - halted=1, inst_valid=0, imem_req=0.
  - Left only by reset.
  - imem_ack and inst_ready are ignored.
- Field outputs are pure slices of the IR and are valid whenever inst_valid=1. When inst_valid=0 they reflect the stale IR and must not be used.
- Throughput: at most one instruction every 2 cycles (FETCH+HOLD). There is no prefetch.
- Stray imem_ack while imem_req=0: ignored, no state change.
- Reset asserted mid-fetch or mid-hold:
  - Immediate return to reset values.
  - The outstanding memory request is abandoned; a late ack after release while in FETCH is accepted as data for RESET_PC.
- pc+PC_STEP is 32-bit unsigned; there is no alignment check in this stage.

Test Plan:
- Reset release, ack at 1st FETCH cycle with imem_data=32'h0109_5020 (add $t2,$t0,$t1):
  - imem_addr=32'h0040_0000.
  - Next cycle inst_valid=1, opcode=0, rs=8, rt=9, rd=10, funct=6'h20.
  - inst_ready=1 gives pc=32'h0040_0004 and imem_req=1.
- Memory delays ack 3 cycles:
  - imem_req and imem_addr are held constant for 3 cycles.
  - IR loads on the 4th; inst_valid rises the following cycle.
- Decoder stall: inst_ready=0 for 5 cycles in HOLD:
  - inst_valid stays 1, outputs unchanged, pc unchanged, imem_req=0.
  - Releasing inst_ready advances pc by 4 in one cycle.
- except=1 together with inst_ready=1 on IR=32'hFC00_0000:
  - halted=1 next cycle, inst_valid=0, imem_req=0, pc unchanged.
  - Further ack/ready pulses have no effect.
- reset asserted for 1 cycle while in HOLD with pc=32'h0040_0010:
  - Asynchronously inst_valid=0, halted=0, pc=32'h0040_0000.
  - After release, fetch restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFFC, accept one instruction: pc wraps to 32'h0000_0000 and the next imem_addr=0.

Source files
------------

// File: rtl/mips_fetch_ir.sv
// ---------------------------------------------------------------------------
// mips_fetch_ir
//
// Instruction fetch / instruction-register stage that feeds mips_decode.
// It holds the program counter and requests one word at a time from
// instruction memory over a req/ack handshake. The returned word is latched
// into the IR and sliced into the MIPS fields used by the decoder and the
// register file. When the decoder reports an unrecognised instruction, the
// stage stops and stays stopped until reset.
//
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   PC_STEP    PC increment after each accepted instruction
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        asynchronous, active-low reset
//   imem_req     fetch request to instruction memory, held until ack
//   imem_addr    fetch address (equals pc)
//   imem_ack     memory returns imem_data this cycle
//   imem_data    instruction word returned by memory
//   inst_valid   IR holds an instruction for the decoder
//   inst_ready   decoder consumes the IR this cycle
//   except       decoder flags the current IR as unrecognised
//   opcode/rs/rt/rd/funct/imm   field slices of the IR
//   pc           address of the IR instruction or of the pending fetch
//   halted       sticky stop flag
// ---------------------------------------------------------------------------
module mips_fetch_ir #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        except,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    // armed_q keeps imem_req low while reset is held and during the gap up to
    // the first rising edge after release; memory never sees a request in
    // that window, and any ack there is ignored.
    logic        armed_q;

    // State, PC, IR and the arming flag. Reset is asynchronous so a stage
    // caught mid-fetch or mid-hold drops back immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            armed_q <= 1'b1;
        end
    end

    // Next-state logic. In HOLD the except check comes before inst_ready, so
    // a faulting instruction is never consumed and the pc stays on it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                if (armed_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (except) begin
                    state_d = HALT;
                end else if (inst_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        imem_req   = (state_q == FETCH) && armed_q;
        imem_addr  = pc_q;
        inst_valid = (state_q == HOLD);
        halted     = (state_q == HALT);
        pc         = pc_q;
    end

    // The field outputs are plain IR slices. They are meaningful only while
    // inst_valid is high; otherwise they show the stale IR.
    always_comb begin
        opcode = ir_q[31:26];
        rs     = ir_q[25:21];
        rt     = ir_q[20:16];
        rd     = ir_q[15:11];
        funct  = ir_q[5:0];
        imm    = ir_q[15:0];
    end

endmodule
